vpu_operand_fetch: RTL and testbench
====================================

// Module: vpu_operand_fetch
// PURPOSE
//  Operand-get stage of the VPU pipeline: on a one-cycle start pulse from the VPU controller,
//  fetches BEATS consecutive words per enabled source operand from the per-source SRAM read ports.
//  Buffers the words in per-source operand queues and pulses done once every word is queued.
//  The controller then pops one word per source per EXEC sub-step through queue_rden_i.
// PARAMETERS
//  SRC_CNT   3    number of source operands / SRAM read ports
//  ADDR_W    16   SRAM word-address width
//  DATA_W    256  SRAM word / operand-queue entry width
//  RD_LAT    2    SRAM read latency in cycles (rden cycle -> rdata valid cycle), >=1
//  BEATS     2    words fetched per source per instruction; also the queue depth
// PORTS
//  clk            in   1               clock
//  rst_n          in   1               reset, synchronous, active-low
//  opget_start_i  in   1               start pulse from controller
//  rvalid_i       in   SRC_CNT         per-source operand-enable from decoded instruction
//  raddr_i        in   SRC_CNT*ADDR_W  per-source base word address; source k at [k*ADDR_W +: ADDR_W]
//  opget_done_o   out  1               one-cycle pulse: all fetched words queued
//  busy_o         out  1               high while a fetch is in progress (not IDLE)
//  sram_rden_o    out  SRC_CNT         per-port read enable
//  sram_raddr_o   out  SRC_CNT*ADDR_W  per-port read address
//  sram_rdata_i   in   SRC_CNT*DATA_W  per-port read data, valid RD_LAT cycles after rden
//  queue_rden_i   in   SRC_CNT         per-queue pop from controller
//  queue_rdata_o  out  SRC_CNT*DATA_W  head entry of each queue (combinational from storage)
//  queue_empty_o  out  SRC_CNT         per-queue empty flag
// BEHAVIOUR
//  Reset: state IDLE; all queues empty; return pipeline cleared.
//   - Outputs at reset: opget_done_o=0, busy_o=0, sram_rden_o=0, sram_raddr_o=0, queue_empty_o=all 1.
//  Start handling:
//   - opget_start_i is sampled only in IDLE; ignored while busy.
//   - At acceptance, rvalid_i and raddr_i are latched and all queues are flushed.
//  FSM:
//   - IDLE -> ISSUE on start.
//   - ISSUE lasts BEATS cycles; beat counter b=0..BEATS-1.
//       sram_rden_o[k]=latched rvalid[k]; sram_raddr_o[k]=base[k]+b, modulo 2^ADDR_W (address wraps, no error).
//       Go to WAIT after beat BEATS-1.
//   - WAIT counts RD_LAT cycles, then goes to DONE.
//   - DONE asserts opget_done_o for exactly one cycle, then goes to IDLE.
//  Timing:
//   - Start sampled at the end of cycle 0: rden in cycles 1..BEATS.
//   - opget_done_o in cycle BEATS+RD_LAT+1.
//   - Latency is fixed and independent of rvalid, including when all sources are disabled.
//  Return path:
//   - An RD_LAT-deep shift pipeline carries each port's rden.
//   - When a port's pipeline tail is 1, sram_rdata_i[k] is pushed into queue k at the end of that cycle.
//  Queues: per-source FIFO, depth BEATS, with pointer and count registers.
//   - A pop on an empty queue is ignored; data and pointers are unchanged.
//   - A push on a full queue cannot occur: the flush at start plus the depth guarantee this. Assert in simulation.
//   - Simultaneous push and pop in one cycle: both take effect and the count is unchanged.
//   - Pointers wrap modulo BEATS.
//   - queue_rdata_o shows the head entry; its value while empty is don't-care.
//  Disabled sources (rvalid=0): no rden and no push; the queue stays empty.
//  Reset mid-operation: FSM, queues and return pipeline are cleared.
//   - Read data returning after reset is discarded.
//   - No done pulse is produced for the aborted fetch.
// TESTING
//  1 Defaults, rvalid=3'b111, bases 0x10/0x20/0x30, start at cycle 0:
//      rden=111 in cycles 1-2 with addresses 0x10,0x11 / 0x20,0x21 / 0x30,0x31.
//      Queues go non-empty in cycle 4; done pulses in cycle 5.
//      Popping twice returns the memory words in address order, then empty=1.
//  2 rvalid=3'b101: port 1 rden stays 0 and queue 1 stays empty; done is still in cycle 5.
//      rvalid=000: done in cycle 5 with no rden.
//  3 Base 0xFFFF on port 0: addresses 0xFFFF then 0x0000.
//  4 Second start during ISSUE/WAIT: ignored, with exactly one done pulse.
//      Back-to-back start in the cycle after done: accepted, and the queues are flushed first.
//  5 Pop on empty queue: no change to empty or data.
//      Pop in the cycle a push lands: the queue depth stays the same.
//  6 rst_n low in cycle 3: no done pulse, all queues empty, and the later rdata is not pushed.
//      A fresh start afterwards completes normally.

Source files
------------

// File: rtl/vpu_operand_fetch.sv
`timescale 1ns/1ps
// Operand-get stage: on start, issues BEATS reads per enabled source and queues the
// returned words in per-source FIFOs; pulses done after a fixed latency.
module vpu_operand_fetch #(
    parameter int unsigned SRC_CNT = 3,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned BEATS   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       opget_start_i,
    input  logic [SRC_CNT-1:0]         rvalid_i,
    input  logic [SRC_CNT*ADDR_W-1:0]  raddr_i,
    output logic                       opget_done_o,
    output logic                       busy_o,
    output logic [SRC_CNT-1:0]         sram_rden_o,
    output logic [SRC_CNT*ADDR_W-1:0]  sram_raddr_o,
    input  logic [SRC_CNT*DATA_W-1:0]  sram_rdata_i,
    input  logic [SRC_CNT-1:0]         queue_rden_i,
    output logic [SRC_CNT*DATA_W-1:0]  queue_rdata_o,
    output logic [SRC_CNT-1:0]         queue_empty_o
);

    localparam int unsigned PTR_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned QCNT_W = $clog2(BEATS + 1);
    localparam int unsigned SEQ_W  = $clog2(BEATS + RD_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                    r_state;
    logic [SEQ_W-1:0]          r_cnt;
    logic [SRC_CNT*ADDR_W-1:0] r_base;
    logic [SRC_CNT-1:0]        r_rden;
    logic [SRC_CNT*ADDR_W-1:0] r_raddr;
    logic                      r_done;
    logic                      r_busy;
    logic [RD_LAT-1:0]         r_pipe [SRC_CNT];
    logic                      w_accept;

    assign w_accept     = (r_state == S_IDLE) && opget_start_i;
    assign opget_done_o = r_done;
    assign busy_o       = r_busy;
    assign sram_rden_o  = r_rden;
    assign sram_raddr_o = r_raddr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
            r_rden  <= '0;
            r_raddr <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (opget_start_i) begin
                        r_state <= S_ISSUE;
                        r_busy  <= 1'b1;
                        r_base  <= raddr_i;
                        r_rden  <= rvalid_i;
                        r_raddr <= raddr_i;
                        r_cnt   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_cnt == SEQ_W'(BEATS - 1)) begin
                        r_state <= S_WAIT;
                        r_rden  <= '0;
                        r_raddr <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        for (int unsigned k = 0; k < SRC_CNT; k++) begin
                            r_raddr[k*ADDR_W +: ADDR_W] <=
                                r_base[k*ADDR_W +: ADDR_W] + ADDR_W'(r_cnt + 1'b1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == SEQ_W'(RD_LAT - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Delayed copy of each port's rden marks the cycle its read data is valid
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < SRC_CNT; k++) begin
            if (!rst_n) begin
                r_pipe[k] <= '0;
            end else begin
                r_pipe[k][0] <= r_rden[k];
                for (int unsigned i = 1; i < RD_LAT; i++) begin
                    r_pipe[k][i] <= r_pipe[k][i-1];
                end
            end
        end
    end

    for (genvar g = 0; g < SRC_CNT; g++) begin : g_queue
        logic [DATA_W-1:0] r_mem [BEATS];
        logic [PTR_W-1:0]  r_wptr;
        logic [PTR_W-1:0]  r_rptr;
        logic [QCNT_W-1:0] r_qcnt;
        logic              w_push;
        logic              w_pop;

        assign w_push = r_pipe[g][RD_LAT-1];
        assign w_pop  = queue_rden_i[g] && (r_qcnt != '0);

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr] <= sram_rdata_i[g*DATA_W +: DATA_W];
            end
        end

        // Flush on accepted start shares the reset path so stale entries never survive
        always_ff @(posedge clk) begin
            if (!rst_n || w_accept) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_qcnt <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= (r_wptr == PTR_W'(BEATS - 1)) ? '0 : r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= (r_rptr == PTR_W'(BEATS - 1)) ? '0 : r_rptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_qcnt <= r_qcnt + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_qcnt <= r_qcnt - 1'b1;
                end
            end
        end

        assign queue_rdata_o[g*DATA_W +: DATA_W] = r_mem[r_rptr];
        assign queue_empty_o[g]                  = (r_qcnt == '0);

        a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
            !(w_push && (r_qcnt == QCNT_W'(BEATS))));
    end

endmodule

// File: tb/tb_vpu_operand_fetch.sv
`timescale 1ns/1ps
// Directed bench for vpu_operand_fetch with a behavioural 2-cycle-latency SRAM model.
module tb_vpu_operand_fetch;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         opget_start_i;
    logic [2:0]   rvalid_i;
    logic [47:0]  raddr_i;
    logic         opget_done_o;
    logic         busy_o;
    logic [2:0]   sram_rden_o;
    logic [47:0]  sram_raddr_o;
    logic [767:0] sram_rdata_i;
    logic [2:0]   queue_rden_i;
    logic [767:0] queue_rdata_o;
    logic [2:0]   queue_empty_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vpu_operand_fetch #(
        .SRC_CNT(3),
        .ADDR_W (16),
        .DATA_W (256),
        .RD_LAT (2),
        .BEATS  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opget_start_i(opget_start_i),
        .rvalid_i     (rvalid_i),
        .raddr_i      (raddr_i),
        .opget_done_o (opget_done_o),
        .busy_o       (busy_o),
        .sram_rden_o  (sram_rden_o),
        .sram_raddr_o (sram_raddr_o),
        .sram_rdata_i (sram_rdata_i),
        .queue_rden_i (queue_rden_i),
        .queue_rdata_o(queue_rdata_o),
        .queue_empty_o(queue_empty_o)
    );

    function automatic logic [255:0] word(input int k, input logic [15:0] a);
        logic [31:0] w;
        w = {16'hA500 | 16'(k), a};
        return {8{w}};
    endfunction

    // SRAM: data for the address presented in cycle c appears in cycle c+2
    logic [47:0] a_d1 = '0;
    logic [47:0] a_d2 = '0;
    always @(posedge clk) begin
        a_d1 <= sram_raddr_o;
        a_d2 <= a_d1;
    end
    always @* begin
        for (int k = 0; k < 3; k++) begin
            sram_rdata_i[k*256 +: 256] = word(k, a_d2[k*16 +: 16]);
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_heads(input string tag, input logic [2:0] en, input logic [47:0] base,
                               input int off);
        logic [15:0] a;
        for (int k = 0; k < 3; k++) begin
            if (en[k]) begin
                a = base[k*16 +: 16] + 16'(off);
                check(tag, queue_rdata_o[k*256 +: 256], word(k, a));
            end
        end
    endtask

    // Start in the current cycle (cycle 0) and walk cycles 1..6; returns in cycle 6
    task automatic fetch(input string tag, input logic [2:0] en, input logic [47:0] base);
        logic [2:0]  exp_rden;
        logic [2:0]  exp_empty;
        logic [15:0] a;
        rvalid_i      = en;
        raddr_i       = base;
        opget_start_i = 1'b1;
        tick;
        opget_start_i = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            exp_rden  = (c <= 2) ? en : 3'b000;
            exp_empty = (c >= 4) ? ~en : 3'b111;
            check({tag, "_rden"}, sram_rden_o, exp_rden);
            check({tag, "_done"}, opget_done_o, c == 5);
            check({tag, "_busy"}, busy_o, c <= 5);
            check({tag, "_empty"}, queue_empty_o, exp_empty);
            if (c <= 2) begin
                for (int k = 0; k < 3; k++) begin
                    if (en[k]) begin
                        a = base[k*16 +: 16] + 16'(c - 1);
                        check({tag, "_addr"}, sram_raddr_o[k*16 +: 16], a);
                    end
                end
            end
            if (c < 6) tick;
        end
    endtask

    localparam logic [47:0] B1 = {16'h0030, 16'h0020, 16'h0010};
    localparam logic [47:0] B2 = {16'h5000, 16'h0777, 16'h1234};
    localparam logic [47:0] B3 = {16'h0000, 16'h0000, 16'hFFFF};
    localparam logic [47:0] B4 = {16'h0300, 16'h0200, 16'h0100};
    localparam logic [47:0] B5 = {16'h0ABC, 16'h0DEF, 16'h0123};
    localparam logic [47:0] B6 = {16'h7000, 16'h6000, 16'h5000};
    localparam logic [47:0] B7 = {16'h00F0, 16'h00E0, 16'h00D0};

    initial begin
        rst_n         = 1'b0;
        opget_start_i = 1'b0;
        rvalid_i      = '0;
        raddr_i       = '0;
        queue_rden_i  = '0;
        tick;
        tick;
        check("rst_done", opget_done_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_rden", sram_rden_o, 3'b000);
        check("rst_raddr", sram_raddr_o, 48'h0);
        check("rst_empty", queue_empty_o, 3'b111);
        rst_n = 1'b1;
        tick;

        // all sources, then pop both words in address order
        fetch("t1", 3'b111, B1);
        check_heads("t1_head0", 3'b111, B1, 0);
        queue_rden_i = 3'b111;
        tick;
        check_heads("t1_head1", 3'b111, B1, 1);
        check("t1_empty_mid", queue_empty_o, 3'b000);
        tick;
        queue_rden_i = 3'b000;
        check("t1_empty_end", queue_empty_o, 3'b111);

        // partial enable, then back-to-back all-disabled start flushes the queues
        fetch("t2a", 3'b101, B2);
        check_heads("t2a_head", 3'b101, B2, 0);
        fetch("t2b", 3'b000, 48'h0);

        // address wrap on port 0
        fetch("t3", 3'b001, B3);
        check_heads("t3_head0", 3'b001, B3, 0);
        queue_rden_i = 3'b001;
        tick;
        check_heads("t3_head1", 3'b001, B3, 1);
        tick;
        queue_rden_i = 3'b000;
        check("t3_empty", queue_empty_o, 3'b111);

        // pop on empty queues changes nothing
        queue_rden_i = 3'b111;
        tick;
        queue_rden_i = 3'b000;
        check("t5_pop_empty", queue_empty_o, 3'b111);
        tick;

        // start held high through ISSUE/WAIT/DONE: exactly one done, no relatch
        rvalid_i      = 3'b111;
        raddr_i       = B4;
        opget_start_i = 1'b1;
        tick;
        raddr_i = 48'h0;
        for (int c = 1; c <= 8; c++) begin
            check("t4_done", opget_done_o, c == 5);
            check("t4_busy", busy_o, c <= 5);
            if (c == 2) check("t4_addr", sram_raddr_o[15:0], 16'h0101);
            if (c == 5) opget_start_i = 1'b0;
            tick;
        end
        check_heads("t4_head0", 3'b111, B4, 0);
        queue_rden_i = 3'b111;
        tick;
        check_heads("t4_head1", 3'b111, B4, 1);
        tick;
        queue_rden_i = 3'b000;
        check("t4_empty", queue_empty_o, 3'b111);

        // pop in the same cycle the second word lands
        rvalid_i      = 3'b111;
        raddr_i       = B5;
        opget_start_i = 1'b1;
        tick;
        opget_start_i = 1'b0;
        tick;
        tick;
        tick;
        check("t5_empty_c4", queue_empty_o, 3'b000);
        check_heads("t5_head_c4", 3'b111, B5, 0);
        queue_rden_i = 3'b111;
        tick;
        check("t5_empty_c5", queue_empty_o, 3'b000);
        check_heads("t5_head_c5", 3'b111, B5, 1);
        check("t5_done", opget_done_o, 1'b1);
        tick;
        queue_rden_i = 3'b000;
        check("t5_empty_c6", queue_empty_o, 3'b111);
        tick;

        // reset in cycle 3 aborts the fetch and drops returning data
        rvalid_i      = 3'b111;
        raddr_i       = B6;
        opget_start_i = 1'b1;
        tick;
        opget_start_i = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int c = 4; c <= 8; c++) begin
            check("t6_done", opget_done_o, 1'b0);
            check("t6_busy", busy_o, 1'b0);
            check("t6_empty", queue_empty_o, 3'b111);
            tick;
        end
        fetch("t6f", 3'b111, B7);
        check_heads("t6f_head0", 3'b111, B7, 0);
        queue_rden_i = 3'b111;
        tick;
        check_heads("t6f_head1", 3'b111, B7, 1);
        tick;
        queue_rden_i = 3'b000;
        check("t6f_empty", queue_empty_o, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
